priority_decoder_accumulator: RTL and testbench

PRIORITY_DECODER_ACCUMULATOR -- requirements
Module: priority_decoder_accumulator

---
 rtl/priority_decoder_accumulator_if.sv | 27 ++
 rtl/priority_decoder_accumulator.sv | 108 ++++++++++
 tb/tb_priority_decoder_accumulator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/priority_decoder_accumulator_if.sv
// Index-beat input stream and reconstructed-vector output stream for priority_decoder_accumulator.
// master drives beats and consumes results; slave is the accumulator side.
interface priority_decoder_accumulator_if #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_index;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_vec;
  logic [IW:0]   out_count;
  logic          out_dup;
  logic          out_err;

  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_dup, out_err
  );

  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_dup, out_err
  );
endinterface

// File: rtl/priority_decoder_accumulator.sv
// Rebuilds a W-bit vector from index beats with distinct-count, duplicate and out-of-range flags; result valid the cycle after the last beat.
// While a result is held, in_ready is 0 until out_ready completes the output handshake.
module priority_decoder_accumulator #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input logic                  clk,
  input logic                  rst,
  priority_decoder_accumulator_if.slave bus
);

  localparam logic [IW:0] W_L = (IW+1)'(W);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  vec_q, vec_d;
  logic [IW:0]   count_q, count_d;
  logic          dup_q, dup_d;
  logic          err_q, err_d;

  logic          collect;
  logic          hold;
  logic          accept;
  logic          release_out;
  logic          in_range;
  logic          hit;
  logic [W-1:0]  onehot;

  assign collect     = (state_q == COLLECT);
  assign hold        = (state_q == HOLD);
  assign accept      = bus.in_valid && collect;
  assign release_out = hold && bus.out_ready;

  // Out-of-range indices only exist when W is not a power of two.
  assign in_range = ({1'b0, bus.in_index} < W_L);
  assign onehot   = in_range ? ({{(W-1){1'b0}}, 1'b1} << bus.in_index) : '0;
  assign hit      = |(vec_q & onehot);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && bus.in_last) state_d = HOLD;
      HOLD:    if (bus.out_ready)         state_d = COLLECT;
      default:                            state_d = COLLECT;
    endcase
  end

  always_comb begin
    bus.in_ready  = collect;
    bus.out_valid = hold;
    bus.out_vec   = vec_q;
    bus.out_count = count_q;
    bus.out_dup   = dup_q;
    bus.out_err   = err_q;
  end

  always_comb begin
    vec_d   = vec_q;
    count_d = count_q;
    dup_d   = dup_q;
    err_d   = err_q;
    if (accept) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else if (hit) begin
        dup_d = 1'b1;
      end else begin
        vec_d   = vec_q | onehot;
        count_d = count_q + (IW+1)'(1);
      end
    end else if (release_out) begin
      vec_d   = '0;
      count_d = '0;
      dup_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q   <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
    end
  end

  // A held result must not move until it has been taken.
  assert property (@(posedge clk) disable iff (rst)
    (hold && !bus.out_ready) |=> $stable({vec_q, count_q, dup_q, err_q}));

  assert property (@(posedge clk) disable iff (rst) count_q <= W_L);

endmodule

// File: tb/tb_priority_decoder_accumulator.sv
// Directed-vector bench for priority_decoder_accumulator at W=16 and W=12.
module tb_priority_decoder_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  priority_decoder_accumulator_if #(.W(16)) if16 ();
  priority_decoder_accumulator_if #(.W(12)) if12 ();

  priority_decoder_accumulator #(.W(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  priority_decoder_accumulator #(.W(12)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (if12.slave)
  );

  // One group: beat k is idx[4k+:4], last beat is number n-1.
  typedef struct packed {
    logic [4:0]  n;
    logic [63:0] idx;
    logic [15:0] vec;
    logic [4:0]  cnt;
    logic        dup;
    logic        err;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit sel12, input logic [3:0] idx, input logic last);
    if (sel12) begin
      if12.in_valid = 1'b1;
      if12.in_index = idx;
      if12.in_last  = last;
    end else begin
      if16.in_valid = 1'b1;
      if16.in_index = idx;
      if16.in_last  = last;
    end
    tick();
    if12.in_valid = 1'b0;
    if16.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{n: 5'd3,  idx: 64'h073,              vec: 16'h0089, cnt: 5'd3,  dup: 1'b0, err: 1'b0};
    tbl[1] = '{n: 5'd3,  idx: 64'h955,              vec: 16'h0220, cnt: 5'd2,  dup: 1'b1, err: 1'b0};
    tbl[2] = '{n: 5'd16, idx: 64'hFEDCBA9876543210, vec: 16'hFFFF, cnt: 5'd16, dup: 1'b0, err: 1'b0};
    tbl[3] = '{n: 5'd1,  idx: 64'hA,                vec: 16'h0400, cnt: 5'd1,  dup: 1'b0, err: 1'b0};
    tbl[4] = '{n: 5'd3,  idx: 64'hFFF,              vec: 16'h8000, cnt: 5'd1,  dup: 1'b1, err: 1'b0};

    rst = 1'b1;
    if16.in_valid  = 1'b1;
    if16.in_index  = 4'd4;
    if16.in_last   = 1'b1;
    if16.out_ready = 1'b0;
    if12.in_valid  = 1'b1;
    if12.in_index  = 4'd3;
    if12.in_last   = 1'b1;
    if12.out_ready = 1'b0;
    tick();
    tick();
    if16.in_valid = 1'b0;
    if12.in_valid = 1'b0;
    rst = 1'b0;

    chk("rst_in_ready",  32'(if16.in_ready),  32'd1);
    chk("rst_out_valid", 32'(if16.out_valid), 32'd0);
    chk("rst_vec",       32'(if16.out_vec),   32'd0);
    chk("rst_count",     32'(if16.out_count), 32'd0);
    chk("rst_dup",       32'(if16.out_dup),   32'd0);
    chk("rst_err",       32'(if16.out_err),   32'd0);
    chk("rst12_state", {28'd0, if12.in_ready, if12.out_valid, if12.out_dup, if12.out_err}, 32'h8);
    chk("rst12_vec",   32'(if12.out_vec), 32'd0);

    if16.out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < int'(tbl[t].n); k++) begin
        beat(1'b0, tbl[t].idx[4*k +: 4], (k == int'(tbl[t].n) - 1));
      end
      chk($sformatf("t%0d_valid", t), {30'd0, if16.out_valid, if16.in_ready}, 32'h2);
      chk($sformatf("t%0d_vec", t),   32'(if16.out_vec),   32'(tbl[t].vec));
      chk($sformatf("t%0d_count", t), 32'(if16.out_count), 32'(tbl[t].cnt));
      chk($sformatf("t%0d_flags", t), {30'd0, if16.out_dup, if16.out_err}, {30'd0, tbl[t].dup, tbl[t].err});
      tick();
      chk($sformatf("t%0d_clear", t),
          {if16.out_valid, if16.in_ready, if16.out_dup, if16.out_err, 5'(if16.out_count), if16.out_vec, 7'd0},
          {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 7'd0});
    end

    if12.out_ready = 1'b1;
    beat(1'b1, 4'd2, 1'b0);
    beat(1'b1, 4'd13, 1'b1);
    chk("w12_valid", 32'(if12.out_valid), 32'd1);
    chk("w12_vec",   32'(if12.out_vec),   32'h004);
    chk("w12_count", 32'(if12.out_count), 32'd1);
    chk("w12_flags", {30'd0, if12.out_dup, if12.out_err}, 32'h1);
    tick();
    beat(1'b1, 4'd12, 1'b1);
    chk("w12_oor_vec",   32'(if12.out_vec),   32'h000);
    chk("w12_oor_count", 32'(if12.out_count), 32'd0);
    chk("w12_oor_err",   {30'd0, if12.out_valid, if12.out_err}, 32'h3);
    tick();

    if16.out_ready = 1'b0;
    beat(1'b0, 4'd1, 1'b0);
    beat(1'b0, 4'd6, 1'b1);
    chk("stall_vec", 32'(if16.out_vec), 32'h0042);
    if16.in_valid = 1'b1;
    if16.in_index = 4'd3;
    if16.in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("stall_c%0d", c),
          {if16.in_ready, if16.out_valid, if16.out_dup, if16.out_err, 5'(if16.out_count), if16.out_vec, 7'd0},
          {1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 16'h0042, 7'd0});
    end
    if16.out_ready = 1'b1;
    tick();
    chk("hs_no_accept", {if16.out_valid, if16.in_ready, 5'(if16.out_count), if16.out_vec, 9'd0},
        {1'b0, 1'b1, 5'd0, 16'h0000, 9'd0});
    tick();
    if16.in_valid = 1'b0;
    chk("after_hs_valid", 32'(if16.out_valid), 32'd1);
    chk("after_hs_vec",   32'(if16.out_vec),   32'h0008);
    chk("after_hs_count", 32'(if16.out_count), 32'd1);
    tick();

    beat(1'b0, 4'd1, 1'b0);
    beat(1'b0, 4'd4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vec", 32'(if16.out_vec), 32'd0);
    beat(1'b0, 4'd2, 1'b1);
    chk("mid_rst_valid", 32'(if16.out_valid), 32'd1);
    chk("mid_rst_grp_vec",   32'(if16.out_vec),   32'h0004);
    chk("mid_rst_grp_count", 32'(if16.out_count), 32'd1);
    tick();

    if16.out_ready = 1'b0;
    beat(1'b0, 4'd5, 1'b1);
    chk("hold_pre_rst", 32'(if16.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst", {29'd0, if16.out_valid, if16.in_ready, |if16.out_vec}, 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
